// File: rtl/adder_tree_seq_ctrl.sv
// Three-sum adder tree (a+b, c+d, and their total) computed over three cycles on one shared adder.
// Optional macro ADDER_TREE_OP_COUNT_EN adds a saturating 16-bit completed-operation counter (op_count).
module adder_tree_seq_ctrl #(
  parameter int A_W = 4,
  parameter int C_W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [A_W-1:0] a,
  input  logic [A_W-1:0] b,
  input  logic [C_W-1:0] c,
  input  logic [C_W-1:0] d,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [A_W:0]   sum1,
  output logic [C_W:0]   sum2,
  output logic [C_W+1:0] sum3,
  output logic           busy
`ifdef ADDER_TREE_OP_COUNT_EN
  ,
  output logic [15:0]    op_count
`endif
);

  if (C_W < A_W) begin : g_width_check
    $error("adder_tree_seq_ctrl: C_W (%0d) must be >= A_W (%0d)", C_W, A_W);
  end

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
  // in_ready and out_valid decode the registered state only, so neither depends on inputs.
  typedef enum logic [2:0] {
    S_IDLE,
    S_ADD_AB,
    S_ADD_CD,
    S_ADD_SUM,
    S_DONE
  } state_t;

  typedef logic [C_W:0]   opnd_t;
  typedef logic [C_W+1:0] sum_t;

  state_t         state;
  state_t         state_nxt;
  logic [A_W-1:0] a_q;
  logic [A_W-1:0] b_q;
  logic [C_W-1:0] c_q;
  logic [C_W-1:0] d_q;
  opnd_t          add_x;
  opnd_t          add_y;
  sum_t           add_s;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:    if (in_valid) state_nxt = S_ADD_AB;
        S_ADD_AB:  state_nxt = S_ADD_CD;
        S_ADD_CD:  state_nxt = S_ADD_SUM;
        S_ADD_SUM: state_nxt = S_DONE;
        S_DONE:    if (out_ready) state_nxt = S_IDLE;
        default:   state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state == S_IDLE);
    out_valid = (state == S_DONE);
    busy      = (state != S_IDLE);
  end

  // The single shared adder; its operand pair is selected by the current step.
  always_comb begin
    add_x = '0;
    add_y = '0;
    case (state)
      S_ADD_AB: begin
        add_x = opnd_t'(a_q);
        add_y = opnd_t'(b_q);
      end
      S_ADD_CD: begin
        add_x = opnd_t'(c_q);
        add_y = opnd_t'(d_q);
      end
      S_ADD_SUM: begin
        add_x = opnd_t'(sum1);
        add_y = sum2;
      end
      default: ;
    endcase
  end

  assign add_s = sum_t'(add_x) + sum_t'(add_y);

  // Flush leaves the sums as they are; only the capture and the step writes are suppressed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q  <= '0;
      b_q  <= '0;
      c_q  <= '0;
      d_q  <= '0;
      sum1 <= '0;
      sum2 <= '0;
      sum3 <= '0;
    end else if (!flush) begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_q <= a;
            b_q <= b;
            c_q <= c;
            d_q <= d;
          end
        end
        S_ADD_AB:  sum1 <= add_s[A_W:0];
        S_ADD_CD:  sum2 <= add_s[C_W:0];
        S_ADD_SUM: sum3 <= add_s;
        default: ;
      endcase
    end
  end

`ifdef ADDER_TREE_OP_COUNT_EN
  logic [15:0] op_count_q;

  // A result abandoned by flush in the same cycle is not counted as delivered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_count_q <= '0;
    end else if (out_valid && out_ready && !flush && (op_count_q != 16'hFFFF)) begin
      op_count_q <= op_count_q + 16'd1;
    end
  end

  assign op_count = op_count_q;
`endif

endmodule
